// File: rtl/ahb_pwm_multi.sv
// rtl/ahb_pwm_multi.sv - multi-channel PWM generator behind a zero-wait AHB-Lite slave
// Per-channel period/duty are double-buffered and take effect at each counter wrap.
module ahb_pwm_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [NUM_CH-1:0] pwm_out
);

  logic              dp_valid;
  logic              dp_write;
  logic [9:0]        dp_addr;
  logic              wr_en;
  logic              sel_ctrl;
  logic              sel_stat;
  logic [NUM_CH-1:0] sel_ch;
  logic [NUM_CH-1:0] wr_period;
  logic [NUM_CH-1:0] wr_duty;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] w1c;
  logic [NUM_CH-1:0] enable;
  logic [NUM_CH-1:0] invert;
  logic [NUM_CH-1:0] flags;
  logic [CNT_W-1:0]  pend_period [NUM_CH];
  logic [CNT_W-1:0]  pend_duty   [NUM_CH];
  logic [CNT_W-1:0]  act_period  [NUM_CH];
  logic [CNT_W-1:0]  act_duty    [NUM_CH];
  logic [CNT_W-1:0]  cnt         [NUM_CH];
  logic              unused_bits;

  assign HREADYOUT   = 1'b1;
  assign HRESP       = 2'b00;
  assign unused_bits = ^{HADDR[31:12], HADDR[1:0], HTRANS[0], HSIZE, HWDATA};

  // dp_addr is a word address: 0x000 CTRL, 0x001 STAT, 0x04x..0x07x channel blocks
  always_comb begin
    wr_en     = dp_valid & dp_write & HREADY;
    sel_ctrl  = (dp_addr == 10'h000);
    sel_stat  = (dp_addr == 10'h001);
    w1c       = (wr_en && sel_stat) ? HWDATA[NUM_CH-1:0] : {NUM_CH{1'b0}};
    sel_ch    = '0;
    wr_period = '0;
    wr_duty   = '0;
    wrap      = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      sel_ch[n]    = (dp_addr[9:6] == 4'h1) && (dp_addr[5:2] == 4'(n));
      wr_period[n] = wr_en && sel_ch[n] && (dp_addr[1:0] == 2'd0);
      wr_duty[n]   = wr_en && sel_ch[n] && (dp_addr[1:0] == 2'd1);
      wrap[n]      = enable[n] && (cnt[n] == act_period[n]);
    end
  end

  always_comb begin
    HRDATA = '0;
    if (dp_valid && !dp_write) begin
      if (sel_ctrl) begin
        HRDATA[NUM_CH-1:0]  = enable;
        HRDATA[16 +: NUM_CH] = invert;
      end
      if (sel_stat) HRDATA[NUM_CH-1:0] = flags;
      for (int n = 0; n < NUM_CH; n++) begin
        if (sel_ch[n]) begin
          case (dp_addr[1:0])
            2'd0:    HRDATA[CNT_W-1:0] = pend_period[n];
            2'd1:    HRDATA[CNT_W-1:0] = pend_duty[n];
            2'd2:    HRDATA[CNT_W-1:0] = cnt[n];
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      enable   <= '0;
      invert   <= '0;
      flags    <= '0;
      pwm_out  <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        pend_period[n] <= '0;
        pend_duty[n]   <= '0;
        act_period[n]  <= '0;
        act_duty[n]    <= '0;
        cnt[n]         <= '0;
      end
    end else begin
      if (HREADY) begin
        dp_valid <= HSEL & HTRANS[1];
        dp_write <= HWRITE;
        dp_addr  <= HADDR[11:2];
      end
      if (wr_en && sel_ctrl) begin
        enable <= HWDATA[NUM_CH-1:0];
        invert <= HWDATA[16 +: NUM_CH];
      end
      // A wrap in the same cycle as a W1C keeps the flag set
      flags <= (flags & ~w1c) | wrap;
      for (int n = 0; n < NUM_CH; n++) begin
        if (wr_period[n]) pend_period[n] <= HWDATA[CNT_W-1:0];
        if (wr_duty[n])   pend_duty[n]   <= HWDATA[CNT_W-1:0];
        if (!enable[n] || wrap[n]) begin
          cnt[n]        <= '0;
          act_period[n] <= pend_period[n];
          act_duty[n]   <= pend_duty[n];
        end else begin
          cnt[n] <= cnt[n] + CNT_W'(1);
        end
        pwm_out[n] <= enable[n] ? ((cnt[n] < act_duty[n]) ^ invert[n]) : invert[n];
      end
    end
  end

endmodule

// File: tb/tb_ahb_pwm_multi.sv
// tb/tb_ahb_pwm_multi.sv - randomized self-checking bench for ahb_pwm_multi
// Expected waveforms come from closed-form period/duty arithmetic relative to the enable edge.
module tb_ahb_pwm_multi;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int HN     = 8192;

  logic              HCLK, HRESET, HSEL, HWRITE, HREADY, HREADYOUT;
  logic [31:0]       HADDR, HWDATA, HRDATA;
  logic [1:0]        HTRANS, HRESP;
  logic [2:0]        HSIZE;
  logic [NUM_CH-1:0] pwm_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_wr = 0;
  logic [NUM_CH-1:0] hist [HN];

  ahb_pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .pwm_out(pwm_out)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  always @(posedge HCLK) cyc <= cyc + 1;
  always @(negedge HCLK) hist[cyc % HN] = pwm_out;

  always @(negedge HCLK) begin
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 2'b00) begin
      failures++;
      $display("FAIL bus_resp hreadyout=%b hresp=%b required 1/00", HREADYOUT, HRESP);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // cycle k after the enable edge shows the counter value of cycle k-1
  function automatic logic exp_pwm(int k, int p, int d0, int d1, int tchg, logic inv);
    int j, c, d;
    if (k < 1) return inv;
    j = (k - 1) / (p + 1);
    c = (k - 1) % (p + 1);
    d = (tchg < (p + 1) * j) ? d1 : d0;
    return (c < d) ^ inv;
  endfunction

  function automatic logic exp_stat(int from, int to, int ten, int p);
    for (int c = from; c <= to; c++)
      if (c > ten && ((c - ten) % (p + 1)) == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HREADY = 1'b1;
  endtask

  task automatic ahb_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {20'h0, a};
    @(negedge HCLK);
    bus_idle(); HWDATA = d;
    @(negedge HCLK);
    last_wr = cyc;
  endtask

  task automatic ahb_read(input logic [11:0] a, output logic [31:0] d, output int t);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {20'h0, a};
    @(negedge HCLK);
    d = HRDATA; t = cyc;
    bus_idle();
  endtask

  task automatic wr_rd(input logic [11:0] a, input logic [31:0] d, output logic [31:0] rd);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {20'h0, a};
    @(negedge HCLK);
    HWDATA = d; HTRANS = 2'b11; HWRITE = 1'b0;
    @(negedge HCLK);
    rd = HRDATA;
    bus_idle();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge HCLK);
  endtask

  task automatic do_reset();
    @(negedge HCLK); HRESET = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK); HRESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int t;
    @(negedge HCLK);
    checks++;
    if (pwm_out !== '0) begin failures++; $display("FAIL reset_initial_pwm got=%h want=0", pwm_out); end
    @(negedge HCLK); HRESET = 1'b0;
    ahb_write(12'h100, 32'd3);
    ahb_write(12'h104, 32'd2);
    ahb_write(12'h000, 32'h0002_0001);
    repeat (6) @(negedge HCLK);
    checks++;
    if (pwm_out[1] !== 1'b1) begin failures++; $display("FAIL reset_pre_invert got=%b want=1", pwm_out[1]); end
    @(negedge HCLK);
    #2 HRESET = 1'b1;
    #1;
    checks++;
    if (pwm_out !== '0) begin failures++; $display("FAIL reset_async_pwm got=%h want=0", pwm_out); end
    @(negedge HCLK);
    @(negedge HCLK); HRESET = 1'b0;
    for (int i = 0; i < 2 + 3 * NUM_CH; i++) begin
      logic [11:0] a;
      a = (i < 2) ? 12'(4 * i) : 12'(256 + 16 * ((i - 2) / 3) + 4 * ((i - 2) % 3));
      ahb_read(a, d, t);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_read addr=%h got=%h want=0", a, d); end
    end
  endtask

  task automatic test_basic();
    int t_en, t, t_c, hi;
    logic [31:0] d;
    ahb_write(12'h100, 32'd9);
    ahb_write(12'h104, 32'd3);
    ahb_write(12'h000, 32'h1);
    t_en = last_wr;
    for (int i = 0; i < 8; i++) begin
      ahb_read(12'h004, d, t);
      checks++;
      if (d !== {31'b0, exp_stat(t_en, t, t_en, 9)})
        begin failures++; $display("FAIL basic_stat k=%0d got=%h want=%h", t - t_en, d, exp_stat(t_en, t, t_en, 9)); end
    end
    wait_until(t_en + 33);
    for (int k = 1; k <= 30; k++) begin
      checks++;
      if (hist[(t_en + k) % HN][0] !== exp_pwm(k, 9, 3, 3, 0, 1'b0))
        begin failures++; $display("FAIL basic_pwm k=%0d got=%b want=%b", k, hist[(t_en + k) % HN][0], exp_pwm(k, 9, 3, 3, 0, 1'b0)); end
    end
    for (int per = 0; per < 3; per++) begin
      hi = 0;
      for (int k = per * 10 + 1; k <= per * 10 + 10; k++) hi += int'(hist[(t_en + k) % HN][0]);
      checks++;
      if (hi !== 3) begin failures++; $display("FAIL basic_high_count period=%0d got=%0d want=3", per, hi); end
    end
    for (int i = 0; i < 3; i++) begin
      ahb_write(12'h004, 32'h1);
      t_c = last_wr;
      repeat ($urandom_range(0, 9)) @(negedge HCLK);
      ahb_read(12'h004, d, t);
      checks++;
      if (d !== {31'b0, exp_stat(t_c, t, t_en, 9)})
        begin failures++; $display("FAIL basic_w1c got=%h want=%h", d, exp_stat(t_c, t, t_en, 9)); end
    end
  endtask

  task automatic test_shadow();
    int t_en, tchg, hi, d1;
    for (int round = 0; round < 2; round++) begin
      d1 = (round == 0) ? 7 : $urandom_range(0, 12);
      ahb_write(12'h000, 32'h0);
      ahb_write(12'h100, 32'd9);
      ahb_write(12'h104, 32'd3);
      ahb_write(12'h000, 32'h1);
      t_en = last_wr;
      repeat ((round == 0) ? $urandom_range(1, 6) : $urandom_range(0, 25)) @(negedge HCLK);
      ahb_write(12'h104, 32'(d1));
      tchg = last_wr - t_en;
      wait_until(t_en + 52);
      for (int k = 1; k <= 50; k++) begin
        checks++;
        if (hist[(t_en + k) % HN][0] !== exp_pwm(k, 9, 3, d1, tchg, 1'b0))
          begin failures++; $display("FAIL shadow_pwm round=%0d k=%0d got=%b want=%b", round, k, hist[(t_en + k) % HN][0], exp_pwm(k, 9, 3, d1, tchg, 1'b0)); end
      end
      if (round == 0) begin
        for (int per = 0; per < 2; per++) begin
          hi = 0;
          for (int k = per * 10 + 1; k <= per * 10 + 10; k++) hi += int'(hist[(t_en + k) % HN][0]);
          checks++;
          if (hi !== ((per == 0) ? 3 : 7))
            begin failures++; $display("FAIL shadow_high_count period=%0d got=%0d want=%0d", per, hi, (per == 0) ? 3 : 7); end
        end
      end
    end
  endtask

  task automatic test_edges();
    int   p_tab [5] = '{9, 9, 9, 9, 0};
    int   d_tab [5] = '{0, 10, 0, 10, 1};
    logic i_tab [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic e_tab [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int t_en, t;
    logic [31:0] d;
    for (int i = 0; i < 5; i++) begin
      ahb_write(12'h000, 32'h0);
      ahb_write(12'h100, 32'(p_tab[i]));
      ahb_write(12'h104, 32'(d_tab[i]));
      ahb_write(12'h000, {15'h0, i_tab[i], 16'h0001});
      t_en = last_wr;
      wait_until(t_en + 23);
      for (int k = 1; k <= 20; k++) begin
        checks++;
        if (hist[(t_en + k) % HN][0] !== e_tab[i])
          begin failures++; $display("FAIL edge_pwm case=%0d k=%0d got=%b want=%b", i, k, hist[(t_en + k) % HN][0], e_tab[i]); end
      end
      if (p_tab[i] == 0) begin
        ahb_write(12'h004, 32'h1);
        ahb_read(12'h004, d, t);
        checks++;
        if (d[0] !== 1'b1) begin failures++; $display("FAIL edge_p0_stat got=%b want=1", d[0]); end
        ahb_read(12'h108, d, t);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL edge_p0_count got=%h want=0", d); end
      end
    end
  endtask

  task automatic test_multi();
    int p [NUM_CH];
    int dd [NUM_CH];
    logic [NUM_CH-1:0] inv;
    int t_en, t;
    logic [31:0] d;
    for (int round = 0; round < 2; round++) begin
      for (int n = 0; n < NUM_CH; n++) begin
        p[n]  = (round == 0) ? 3 + n : $urandom_range(0, 12);
        dd[n] = (round == 0) ? 1 : $urandom_range(0, 14);
      end
      inv = (round == 0) ? '0 : NUM_CH'($urandom_range(0, 15));
      ahb_write(12'h000, 32'h0);
      for (int n = 0; n < NUM_CH; n++) begin
        ahb_write(12'(256 + 16 * n), 32'(p[n]));
        ahb_write(12'(260 + 16 * n), 32'(dd[n]));
      end
      ahb_write(12'h000, {12'h0, inv, 12'h0, 4'hF});
      t_en = last_wr;
      for (int n = 0; n < NUM_CH; n++) begin
        ahb_read(12'(264 + 16 * n), d, t);
        checks++;
        if (d !== 32'((t - t_en) % (p[n] + 1)))
          begin failures++; $display("FAIL multi_count ch=%0d got=%0d want=%0d", n, d, (t - t_en) % (p[n] + 1)); end
      end
      wait_until(t_en + 44);
      for (int n = 0; n < NUM_CH; n++) begin
        for (int k = 1; k <= 40; k++) begin
          checks++;
          if (hist[(t_en + k) % HN][n] !== exp_pwm(k, p[n], dd[n], dd[n], 0, inv[n]))
            begin failures++; $display("FAIL multi_pwm round=%0d ch=%0d k=%0d got=%b want=%b", round, n, k, hist[(t_en + k) % HN][n], exp_pwm(k, p[n], dd[n], dd[n], 0, inv[n])); end
        end
      end
    end
  endtask

  task automatic test_bus();
    logic [31:0] d, rd, want;
    logic [11:0] unm [5] = '{12'h200, 12'h10C, 12'h140, 12'h008, 12'hFFC};
    int t;
    do_reset();
    for (int n = 0; n < NUM_CH; n++) begin
      for (int r = 0; r < 3; r++) begin
        d = $urandom;
        wr_rd(12'(256 + 16 * n + 4 * r), d, rd);
        want = (r == 2) ? 32'h0 : (d & 32'h0000_FFFF);
        checks++;
        if (rd !== want) begin failures++; $display("FAIL bus_b2b ch=%0d reg=%0d got=%h want=%h", n, r, rd, want); end
      end
    end
    wr_rd(12'h004, $urandom, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL bus_stat got=%h want=0", rd); end
    for (int i = 0; i < 5; i++) begin
      wr_rd(unm[i], $urandom, rd);
      checks++;
      if (rd !== 32'h0) begin failures++; $display("FAIL bus_unmapped addr=%h got=%h want=0", unm[i], rd); end
    end
    d = $urandom;
    wr_rd(12'h000, d, rd);
    checks++;
    if (rd !== (d & 32'h000F_000F)) begin failures++; $display("FAIL bus_ctrl got=%h want=%h", rd, d & 32'h000F_000F); end
    ahb_write(12'h000, 32'h0);
    ahb_write(12'h100, 32'h55);
    for (int v = 0; v < 3; v++) begin
      @(negedge HCLK);
      HSEL = (v != 1); HTRANS = (v == 0) ? 2'b00 : 2'b10; HWRITE = 1'b1; HADDR = 32'h100; HREADY = (v != 2);
      @(negedge HCLK);
      bus_idle(); HWDATA = 32'hAA;
      @(negedge HCLK);
      ahb_read(12'h100, rd, t);
      checks++;
      if (rd !== 32'h55) begin failures++; $display("FAIL bus_no_write variant=%0d got=%h want=55", v, rd); end
    end
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h100;
    @(negedge HCLK);
    HWDATA = 32'h1234; HTRANS = 2'b11; HADDR = 32'h104;
    @(negedge HCLK);
    HWDATA = 32'h0042; bus_idle();
    @(negedge HCLK);
    ahb_read(12'h100, rd, t);
    checks++;
    if (rd !== 32'h1234) begin failures++; $display("FAIL bus_pipelined_period got=%h want=1234", rd); end
    ahb_read(12'h104, rd, t);
    checks++;
    if (rd !== 32'h0042) begin failures++; $display("FAIL bus_pipelined_duty got=%h want=42", rd); end
  endtask

  initial begin
    HRESET = 1'b1;
    HWDATA = '0;
    HSIZE  = 3'b010;
    bus_idle();
    test_reset();
    test_basic();
    test_shadow();
    test_edges();
    test_multi();
    test_bus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
